// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with start-glitch rejection, parity/framing flags and a
// valid/ready output register with sticky overrun. Optional: UART_RX_MAJORITY_EN (3-sample vote).
module uart_rx_ext #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = M + 1;
`else
  localparam int DEC = M;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d, pe_q, pe_d, fe_q, fe_d;
  logic [DATA_BITS-1:0] dout_q;
  logic                 dv_q, perr_q, ferr_q, ovr_q;
  logic                 bit_val, dec, done, load;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] smp_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q <= 2'b11;
    end else if (baud_tick && state_q != S_IDLE) begin
      if (tick_q == CW'(M - 1)) smp_q[0] <= rxs_q;
      if (tick_q == CW'(M))     smp_q[1] <= rxs_q;
    end
  end
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
`else
  assign bit_val = rxs_q;
`endif

  assign dec = baud_tick && (state_q != S_IDLE) && (tick_q == CW'(DEC));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    done    = 1'b0;

    // The tick counter idles at zero so the first tick seen in START is count 0.
    if (state_q == S_IDLE)
      tick_d = '0;
    else if (baud_tick)
      tick_d = (tick_q == CW'(OVERSAMPLE - 1)) ? '0 : tick_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        par_d = 1'b0;
        pe_d  = 1'b0;
        fe_d  = 1'b0;
        if (rxs_prev_q && !rxs_q) state_d = S_START;
      end
      S_START: begin
        if (dec) begin
          bit_d   = '0;
          state_d = bit_val ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (dec) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_val;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (dec) begin
          pe_d    = (PARITY == 1) ? ~(par_q ^ bit_val) : (par_q ^ bit_val);
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (dec) begin
          if (!bit_val) fe_d = 1'b1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  // A consumer taking the old word in the delivery cycle frees the register for the new one.
  assign load = done && (!dv_q || data_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (load) begin
      dout_q <= shift_q;
      perr_q <= pe_q;
      ferr_q <= fe_d;
      dv_q   <= 1'b1;
    end else if (done) begin
      ovr_q  <= 1'b1;
    end else if (dv_q && data_ready) begin
      dv_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 and an 8E1 instance, vector table plus scoreboard queues,
// with hand-written sequences for false start, overrun and mid-frame reset.
module tb_uart_rx_ext;
  localparam int OS = 16;

  logic       clk = 1'b0, rst = 1'b1, baud_tick = 1'b0;
  logic       rx_n = 1'b1, rx_e = 1'b1, rdy_n = 1'b1, rdy_e = 1'b1;
  logic [7:0] dn, de;
  logic       vn, ve, pn, pe, fn, fe, on, oe, bn, be;

  always #5 clk = ~clk;

  uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_n), .data_out(dn), .data_valid(vn),
    .data_ready(rdy_n), .parity_err(pn), .frame_err(fn), .overrun(on), .busy(bn));

  uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_e), .data_out(de), .data_valid(ve),
    .data_ready(rdy_e), .parity_err(pe), .frame_err(fe), .overrun(oe), .busy(be));

  typedef struct packed { logic [7:0] d; logic pe; logic fe; } exp_t;
  typedef struct { bit sel; logic [7:0] d; bit pflip; bit slow; int glitch; exp_t e; } vec_t;

  exp_t qn[$], qe[$];
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: data_valid handshake with no frame expected", nm);
  endtask

  // Scoreboard: every accepted word is popped and compared against the queue.
  always @(negedge clk) begin : mon
    exp_t x;
    if (!rst) begin
      if (vn && rdy_n) begin
        if (qn.size() == 0) unexpected("n_unexp");
        else begin
          x = qn.pop_front();
          chk("n_data", dn, x.d); chk("n_perr", pn, x.pe); chk("n_ferr", fn, x.fe);
        end
      end
      if (ve && rdy_e) begin
        if (qe.size() == 0) unexpected("e_unexp");
        else begin
          x = qe.pop_front();
          chk("e_data", de, x.d); chk("e_perr", pe, x.pe); chk("e_ferr", fe, x.fe);
        end
      end
    end
  end

  // One oversample slot: rx set, three quiet clocks, then a one-clock baud_tick.
  task automatic slot(input bit sel, input logic v);
    if (sel) rx_e = v; else rx_n = v;
    repeat (3) begin @(posedge clk); #1; end
    baud_tick = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_n = 1'b1; rx_e = 1'b1;
    for (int i = 0; i < n; i++) slot(1'b0, 1'b1);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit pflip,
                            input bit slow, input int glitch);
    logic [11:0] bits;
    int          n;
    logic        v;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (sel) begin
      bits[9]  = (^d) ^ pflip;
      bits[10] = ~slow;
      n = 11;
    end else begin
      bits[9] = ~slow;
      n = 10;
    end
    for (int b = 0; b < n; b++)
      for (int s = 0; s < OS; s++) begin
        v = bits[b];
        if (b * OS + s == glitch) v = 1'b0;
        slot(sel, v);
      end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.sel) qe.push_back(v.e); else qn.push_back(v.e);
    send_frame(v.sel, v.d, v.pflip, v.slow, v.glitch);
    idle(4);
  endtask

  vec_t vt[9];
  vec_t hv;

  initial begin
    vt[0] = '{0, 8'hA5, 0, 0, -1, '{8'hA5, 1'b0, 1'b0}};
    vt[1] = '{0, 8'h5A, 0, 1, -1, '{8'h5A, 1'b0, 1'b1}};
    vt[2] = '{0, 8'h11, 0, 0, -1, '{8'h11, 1'b0, 1'b0}};
    vt[3] = '{1, 8'h03, 0, 0, -1, '{8'h03, 1'b0, 1'b0}};
    vt[4] = '{1, 8'h03, 1, 0, -1, '{8'h03, 1'b1, 1'b0}};
    vt[5] = '{1, 8'hC1, 1, 0, -1, '{8'hC1, 1'b1, 1'b0}};
    vt[6] = '{1, 8'h80, 0, 1, -1, '{8'h80, 1'b0, 1'b1}};
`ifdef UART_RX_MAJORITY_EN
    vt[7] = '{0, 8'hFF, 0, 0, OS + OS/2, '{8'hFF, 1'b0, 1'b0}};
`else
    vt[7] = '{0, 8'hFF, 0, 0, OS + OS/2, '{8'hFE, 1'b0, 1'b0}};
`endif
    vt[8] = '{0, 8'h00, 0, 0, -1, '{8'h00, 1'b0, 1'b0}};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_n_outs", {dn, vn, pn, fn, on, bn}, 0);
    chk("rst_e_outs", {de, ve, pe, fe, oe, be}, 0);
    idle(2);

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // False start: 4 low slots, then high; receiver must fall back to IDLE silently.
    slot(0, 1'b0); slot(0, 1'b0);
    chk("fs_busy_hi", bn, 1);
    slot(0, 1'b0); slot(0, 1'b0);
    idle(12);
    chk("fs_busy_lo", bn, 0);
    chk("fs_valid", vn, 0);
    hv = '{0, 8'h3C, 0, 0, -1, '{8'h3C, 1'b0, 1'b0}};
    run_vec(hv);

    // Overrun: consumer stalled across two back-to-back frames.
    rdy_n = 1'b0;
    qn.push_back('{8'h12, 1'b0, 1'b0});
    send_frame(0, 8'h12, 0, 0, -1);
    send_frame(0, 8'h34, 0, 0, -1);
    idle(2);
    chk("ovr_data", dn, 8'h12);
    chk("ovr_valid", vn, 1);
    chk("ovr_flag", on, 1);
    @(posedge clk); #1 rdy_n = 1'b1;
    @(posedge clk); #1 rdy_n = 1'b0;
    chk("ovr_clr_valid", vn, 0);
    chk("ovr_clr_flag", on, 0);

    // Mid-frame reset with an unconsumed word held: everything returns to reset values.
    send_frame(0, 8'h77, 0, 0, -1);
    idle(2);
    chk("pre_rst_valid", vn, 1);
    for (int s = 0; s < 5 * OS; s++) slot(0, 1'b0);
    for (int s = 0; s < 4; s++) slot(0, 1'b1);
    chk("pre_rst_busy", bn, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {dn, vn, pn, fn, on, bn}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rdy_n = 1'b1;
    idle(5 * OS);
    chk("post_rst_outs", {dn, vn, pn, fn, on, bn}, 0);
    hv = '{0, 8'h69, 0, 0, -1, '{8'h69, 1'b0, 1'b0}};
    run_vec(hv);

    idle(4);
    chk("qn_empty", qn.size(), 0);
    chk("qe_empty", qe.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
